// File: rtl/tlb_unit_if.sv
// ============================================================================
// Module      : tlb_unit_if
// Description : TLB instruction handshake, CP0 value/result and translation bus.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface tlb_unit_if;
    logic        op_valid;
    logic [3:0]  tlb_op;
    logic        op_ready;
    logic        op_done;
    logic [31:0] entry_hi_W;
    logic [31:0] entry_lo0_W;
    logic [31:0] entry_lo1_W;
    logic [31:0] index_W;
    logic [31:0] random_W;
    logic [31:0] entry_hi_out;
    logic [31:0] entry_lo0_out;
    logic [31:0] entry_lo1_out;
    logic [31:0] page_mask_out;
    logic [31:0] index_out;
    logic        tr_req;
    logic [31:0] tr_vaddr;
    logic        tr_store;
    logic        tr_valid;
    logic [31:0] tr_paddr;
    logic        tr_miss;
    logic        tr_invalid;
    logic        tr_modified;

    modport master (
        output op_valid, tlb_op, entry_hi_W, entry_lo0_W, entry_lo1_W, index_W, random_W,
        output tr_req, tr_vaddr, tr_store,
        input  op_ready, op_done, entry_hi_out, entry_lo0_out, entry_lo1_out,
        input  page_mask_out, index_out,
        input  tr_valid, tr_paddr, tr_miss, tr_invalid, tr_modified
    );

    modport slave (
        input  op_valid, tlb_op, entry_hi_W, entry_lo0_W, entry_lo1_W, index_W, random_W,
        input  tr_req, tr_vaddr, tr_store,
        output op_ready, op_done, entry_hi_out, entry_lo0_out, entry_lo1_out,
        output page_mask_out, index_out,
        output tr_valid, tr_paddr, tr_miss, tr_invalid, tr_modified
    );
endinterface

`default_nettype wire

// File: rtl/tlb_unit.sv
// ============================================================================
// Module      : tlb_unit
// Description : MIPS-style 4 KB-page TLB with tlbp/tlbr/tlbwi/tlbwr and lookup.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tlb_unit #(
    parameter int TLB_LINE_NUM = 16
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    tlb_unit_if.slave   bus
);
    localparam int         c_iw       = $clog2(TLB_LINE_NUM);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_exec  = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            w_op_ready;
    logic            w_op_done;
    logic            w_accept;
    logic [3:0]      w_op_sel;

    logic [3:0]      r_op;
    logic [18:0]     r_l_vpn2;
    logic [7:0]      r_l_asid;
    logic [25:0]     r_l_lo0;
    logic [25:0]     r_l_lo1;
    logic [c_iw-1:0] r_l_idx;
    logic [c_iw-1:0] r_l_rnd;

    logic [18:0]     r_vpn2 [TLB_LINE_NUM];
    logic [7:0]      r_asid [TLB_LINE_NUM];
    logic            r_g    [TLB_LINE_NUM];
    logic [19:0]     r_pfn0 [TLB_LINE_NUM];
    logic [2:0]      r_c0   [TLB_LINE_NUM];
    logic            r_d0   [TLB_LINE_NUM];
    logic            r_v0   [TLB_LINE_NUM];
    logic [19:0]     r_pfn1 [TLB_LINE_NUM];
    logic [2:0]      r_c1   [TLB_LINE_NUM];
    logic            r_d1   [TLB_LINE_NUM];
    logic            r_v1   [TLB_LINE_NUM];

    logic [31:0]     r_entry_hi_out, r_entry_lo0_out, r_entry_lo1_out;
    logic [31:0]     r_page_mask_out, r_index_out;
    logic            r_tr_valid, r_tr_miss, r_tr_invalid, r_tr_modified;
    logic [31:0]     r_tr_paddr;

    logic            w_wr_en;
    logic [c_iw-1:0] w_wr_idx;
    logic            w_p_hit;
    logic [c_iw-1:0] w_p_idx;
    logic            w_t_hit;
    logic [c_iw-1:0] w_t_idx;
    logic            w_unused_ok;

    // Lowest set bit wins: tlbp > tlbr > tlbwi > tlbwr.
    always_comb begin
        w_op_sel = 4'b0000;
        if (bus.tlb_op[0])      w_op_sel = 4'b0001;
        else if (bus.tlb_op[1]) w_op_sel = 4'b0010;
        else if (bus.tlb_op[2]) w_op_sel = 4'b0100;
        else if (bus.tlb_op[3]) w_op_sel = 4'b1000;
    end

    assign w_accept = (r_state == c_st_idle) && bus.op_valid && (|bus.tlb_op);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= c_st_idle;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next_state = c_st_exec;
            c_st_exec: w_next_state = c_st_resp;
            c_st_resp: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_op_ready = 1'b0;
        w_op_done  = 1'b0;
        case (r_state)
            c_st_idle: w_op_ready = 1'b1;
            c_st_resp: w_op_done  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op     <= '0;
            r_l_vpn2 <= '0;
            r_l_asid <= '0;
            r_l_lo0  <= '0;
            r_l_lo1  <= '0;
            r_l_idx  <= '0;
            r_l_rnd  <= '0;
        end else if (w_accept) begin
            r_op     <= w_op_sel;
            r_l_vpn2 <= bus.entry_hi_W[31:13];
            r_l_asid <= bus.entry_hi_W[7:0];
            r_l_lo0  <= bus.entry_lo0_W[25:0];
            r_l_lo1  <= bus.entry_lo1_W[25:0];
            r_l_idx  <= bus.index_W[c_iw-1:0];
            r_l_rnd  <= bus.random_W[c_iw-1:0];
        end
    end

    assign w_wr_en  = (r_state == c_st_exec) && (r_op[2] || r_op[3]);
    assign w_wr_idx = r_op[2] ? r_l_idx : r_l_rnd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_LINE_NUM; i++) begin
                r_vpn2[i] <= '0; r_asid[i] <= '0; r_g[i] <= 1'b0;
                r_pfn0[i] <= '0; r_c0[i] <= '0; r_d0[i] <= 1'b0; r_v0[i] <= 1'b0;
                r_pfn1[i] <= '0; r_c1[i] <= '0; r_d1[i] <= 1'b0; r_v1[i] <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_vpn2[w_wr_idx] <= r_l_vpn2;
            r_asid[w_wr_idx] <= r_l_asid;
            r_g[w_wr_idx]    <= r_l_lo0[0] & r_l_lo1[0];
            r_pfn0[w_wr_idx] <= r_l_lo0[25:6];
            r_c0[w_wr_idx]   <= r_l_lo0[5:3];
            r_d0[w_wr_idx]   <= r_l_lo0[2];
            r_v0[w_wr_idx]   <= r_l_lo0[1];
            r_pfn1[w_wr_idx] <= r_l_lo1[25:6];
            r_c1[w_wr_idx]   <= r_l_lo1[5:3];
            r_d1[w_wr_idx]   <= r_l_lo1[2];
            r_v1[w_wr_idx]   <= r_l_lo1[1];
        end
    end

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_p_hit = 1'b0;
        w_p_idx = '0;
        for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
            if (r_vpn2[i] == r_l_vpn2 && (r_g[i] || r_asid[i] == r_l_asid)) begin
                w_p_hit = 1'b1;
                w_p_idx = c_iw'(i);
            end
        end
    end

    always_comb begin
        w_t_hit = 1'b0;
        w_t_idx = '0;
        for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
            if (r_vpn2[i] == bus.tr_vaddr[31:13] &&
                (r_g[i] || r_asid[i] == bus.entry_hi_W[7:0])) begin
                w_t_hit = 1'b1;
                w_t_idx = c_iw'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_entry_hi_out  <= '0;
            r_entry_lo0_out <= '0;
            r_entry_lo1_out <= '0;
            r_page_mask_out <= '0;
            r_index_out     <= '0;
        end else if (r_state == c_st_exec) begin
            if (r_op[0]) begin
                r_index_out <= w_p_hit ? {{(32 - c_iw){1'b0}}, w_p_idx} : 32'h8000_0000;
            end
            if (r_op[1]) begin
                r_entry_hi_out  <= {r_vpn2[r_l_idx], 5'b0, r_asid[r_l_idx]};
                r_entry_lo0_out <= {6'b0, r_pfn0[r_l_idx], r_c0[r_l_idx], r_d0[r_l_idx],
                                    r_v0[r_l_idx], r_g[r_l_idx]};
                r_entry_lo1_out <= {6'b0, r_pfn1[r_l_idx], r_c1[r_l_idx], r_d1[r_l_idx],
                                    r_v1[r_l_idx], r_g[r_l_idx]};
                r_page_mask_out <= '0;
            end
        end
    end

    // Lookup reads the array before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tr_valid    <= 1'b0;
            r_tr_paddr    <= '0;
            r_tr_miss     <= 1'b0;
            r_tr_invalid  <= 1'b0;
            r_tr_modified <= 1'b0;
        end else begin
            r_tr_valid <= bus.tr_req;
            if (bus.tr_req) begin
                if (bus.tr_vaddr[31:30] == 2'b10) begin
                    r_tr_paddr    <= bus.tr_vaddr & 32'h1FFF_FFFF;
                    r_tr_miss     <= 1'b0;
                    r_tr_invalid  <= 1'b0;
                    r_tr_modified <= 1'b0;
                end else if (!w_t_hit) begin
                    r_tr_paddr    <= '0;
                    r_tr_miss     <= 1'b1;
                    r_tr_invalid  <= 1'b0;
                    r_tr_modified <= 1'b0;
                end else if (bus.tr_vaddr[12]) begin
                    r_tr_miss     <= 1'b0;
                    r_tr_invalid  <= ~r_v1[w_t_idx];
                    r_tr_modified <= r_v1[w_t_idx] & bus.tr_store & ~r_d1[w_t_idx];
                    r_tr_paddr    <= (~r_v1[w_t_idx] | (bus.tr_store & ~r_d1[w_t_idx])) ? 32'h0
                                     : {r_pfn1[w_t_idx], bus.tr_vaddr[11:0]};
                end else begin
                    r_tr_miss     <= 1'b0;
                    r_tr_invalid  <= ~r_v0[w_t_idx];
                    r_tr_modified <= r_v0[w_t_idx] & bus.tr_store & ~r_d0[w_t_idx];
                    r_tr_paddr    <= (~r_v0[w_t_idx] | (bus.tr_store & ~r_d0[w_t_idx])) ? 32'h0
                                     : {r_pfn0[w_t_idx], bus.tr_vaddr[11:0]};
                end
            end
        end
    end

    assign bus.op_ready      = w_op_ready;
    assign bus.op_done       = w_op_done;
    assign bus.entry_hi_out  = r_entry_hi_out;
    assign bus.entry_lo0_out = r_entry_lo0_out;
    assign bus.entry_lo1_out = r_entry_lo1_out;
    assign bus.page_mask_out = r_page_mask_out;
    assign bus.index_out     = r_index_out;
    assign bus.tr_valid      = r_tr_valid;
    assign bus.tr_paddr      = r_tr_paddr;
    assign bus.tr_miss       = r_tr_miss;
    assign bus.tr_invalid    = r_tr_invalid;
    assign bus.tr_modified   = r_tr_modified;

    assign w_unused_ok = ^{bus.entry_hi_W[12:8], bus.entry_lo0_W[31:26], bus.entry_lo1_W[31:26],
                           bus.index_W[31:c_iw], bus.random_W[31:c_iw]};

endmodule

`default_nettype wire

// File: tb/tb_tlb_unit.sv
// ============================================================================
// Module      : tb_tlb_unit
// Description : Directed self-checking bench for tlb_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_unit;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    tlb_unit_if bus ();

    tlb_unit #(.TLB_LINE_NUM(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic translate(input logic [31:0] va, input logic st, input logic [7:0] asid);
        bus.tr_req     = 1'b1;
        bus.tr_vaddr   = va;
        bus.tr_store   = st;
        bus.entry_hi_W = {24'h0, asid};
        tick;
        bus.tr_req     = 1'b0;
    endtask

    task automatic chk_tr(input string tag, input logic [31:0] pa, input logic [2:0] flags);
        chk({tag, "_valid"}, {31'h0, bus.tr_valid}, 32'h1);
        chk({tag, "_paddr"}, bus.tr_paddr, pa);
        chk({tag, "_flags"}, {29'h0, bus.tr_miss, bus.tr_invalid, bus.tr_modified},
            {29'h0, flags});
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [31:0] idx, input logic [31:0] rnd);
        bus.op_valid    = 1'b1;
        bus.tlb_op      = op;
        bus.entry_hi_W  = hi;
        bus.entry_lo0_W = lo0;
        bus.entry_lo1_W = lo1;
        bus.index_W     = idx;
        bus.random_W    = rnd;
        chk("op_ready_idle", {31'h0, bus.op_ready}, 32'h1);
        tick;
        bus.op_valid = 1'b0;
        bus.tlb_op   = 4'h0;
        chk("op_exec", {30'h0, bus.op_ready, bus.op_done}, 32'h0);
        tick;
        chk("op_resp", {30'h0, bus.op_ready, bus.op_done}, 32'h1);
        tick;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn = 1'b0;
        bus.op_valid = 1'b0; bus.tlb_op = 4'h0;
        bus.entry_hi_W = '0; bus.entry_lo0_W = '0; bus.entry_lo1_W = '0;
        bus.index_W = '0; bus.random_W = '0;
        bus.tr_req = 1'b0; bus.tr_vaddr = '0; bus.tr_store = 1'b0;
        tick; tick;
        resetn = 1'b1;
        tick;
        chk("rst_ready", {31'h0, bus.op_ready}, 32'h1);
        chk("rst_done", {31'h0, bus.op_done}, 32'h0);
        chk("rst_index", bus.index_out, 32'h0);
        chk("rst_hi", bus.entry_hi_out, 32'h0);
        chk("rst_trv", {31'h0, bus.tr_valid}, 32'h0);

        // Empty TLB: mapped miss, kseg1 passthrough
        translate(32'h0040_0000, 1'b0, 8'd0);
        chk_tr("tr_empty", 32'h0, 3'b100);
        translate(32'hA000_1234, 1'b0, 8'd0);
        chk_tr("tr_kseg1", 32'h0000_1234, 3'b000);
        tick;
        chk("tr_idle", {31'h0, bus.tr_valid}, 32'h0);

        // tlbwi idx3: VPN2 0x200 ASID5 G=1, PFN0 0x41 D V, PFN1 0x81 D ~V
        do_op(4'b0100, 32'h0040_0005, 32'h0000_1047, 32'h0000_2045, 32'd3, 32'd0);
        translate(32'h0040_0ABC, 1'b0, 8'd5);
        chk_tr("tr_p0", 32'h0004_1ABC, 3'b000);
        translate(32'h0040_1ABC, 1'b1, 8'd5);
        chk_tr("tr_p1_inv", 32'h0, 3'b010);
        translate(32'h0040_0ABC, 1'b1, 8'd9);
        chk_tr("tr_global", 32'h0004_1ABC, 3'b000);

        do_op(4'b0001, 32'h0040_0005, 32'h0, 32'h0, 32'd0, 32'd0);
        chk("tlbp_hit3", bus.index_out, 32'h0000_0003);
        chk("tlbp_hold_hi", bus.entry_hi_out, 32'h0);
        do_op(4'b0001, 32'h0040_0006, 32'h0, 32'h0, 32'd0, 32'd0);
        chk("tlbp_g_hit", bus.index_out, 32'h0000_0003);

        do_op(4'b0010, 32'h0, 32'h0, 32'h0, 32'd3, 32'd0);
        chk("tlbr_hi", bus.entry_hi_out, 32'h0040_0005);
        chk("tlbr_lo0", bus.entry_lo0_out, 32'h0000_1047);
        chk("tlbr_lo1", bus.entry_lo1_out, 32'h0000_2045);
        chk("tlbr_pm", bus.page_mask_out, 32'h0);
        chk("tlbr_hold_idx", bus.index_out, 32'h0000_0003);

        // tlbwr random 4: VPN2 0x400 ASID7 G=0, PFN0 0xC0 D V, PFN1 0x100 ~D V
        do_op(4'b1000, 32'h0080_0007, 32'h0000_3006, 32'h0000_4002, 32'd9, 32'd4);
        translate(32'h0080_1234, 1'b1, 8'd7);
        chk_tr("tr_mod", 32'h0, 3'b001);
        translate(32'h0080_1234, 1'b0, 8'd7);
        chk_tr("tr_p1_load", 32'h0010_0234, 3'b000);
        translate(32'h0080_0010, 1'b0, 8'd6);
        chk_tr("tr_asid_miss", 32'h0, 3'b100);
        do_op(4'b0001, 32'h0080_0006, 32'h0, 32'h0, 32'd0, 32'd0);
        chk("tlbp_miss", bus.index_out, 32'h8000_0000);
        do_op(4'b0001, 32'h0080_0007, 32'h0, 32'h0, 32'd0, 32'd0);
        chk("tlbp_hit4", bus.index_out, 32'h0000_0004);

        // Lookup on the same edge as a tlbwi write sees old contents
        bus.op_valid = 1'b1; bus.tlb_op = 4'b0100;
        bus.entry_hi_W = 32'h0100_0001; bus.entry_lo0_W = 32'h0000_6003;
        bus.entry_lo1_W = 32'h0000_6003; bus.index_W = 32'd6;
        tick;
        bus.op_valid = 1'b0; bus.tlb_op = 4'h0;
        bus.tr_req = 1'b1; bus.tr_vaddr = 32'h0100_0000; bus.tr_store = 1'b0;
        tick;
        bus.tr_req = 1'b0;
        chk_tr("tr_prewrite", 32'h0, 3'b100);
        tick;
        translate(32'h0100_0000, 1'b0, 8'd1);
        chk_tr("tr_postwrite", 32'h0018_0000, 3'b000);

        // Held op_valid, tlb_op 1001: tlbp only, single acceptance
        bus.op_valid = 1'b1; bus.tlb_op = 4'b1001;
        bus.entry_hi_W = 32'h0040_0005; bus.entry_lo0_W = 32'h0000_1047;
        bus.entry_lo1_W = 32'h0000_2045; bus.index_W = 32'd4; bus.random_W = 32'd4;
        tick;
        chk("hold_exec", {30'h0, bus.op_ready, bus.op_done}, 32'h0);
        tick;
        chk("hold_resp", {30'h0, bus.op_ready, bus.op_done}, 32'h1);
        chk("prio_tlbp", bus.index_out, 32'h0000_0003);
        tick;
        chk("hold_idle", {30'h0, bus.op_ready, bus.op_done}, 32'h2);
        bus.op_valid = 1'b0; bus.tlb_op = 4'h0;
        tick;
        do_op(4'b0010, 32'h0, 32'h0, 32'h0, 32'd4, 32'd0);
        chk("prio_no_write", bus.entry_hi_out, 32'h0080_0007);

        // op_valid with no op bits is ignored
        bus.op_valid = 1'b1; bus.tlb_op = 4'h0;
        tick;
        bus.op_valid = 1'b0;
        chk("zero_op_ready", {30'h0, bus.op_ready, bus.op_done}, 32'h2);
        tick;
        chk("zero_op_done", {30'h0, bus.op_ready, bus.op_done}, 32'h2);

        // Reset during EXEC of tlbwi idx5 aborts the write
        bus.op_valid = 1'b1; bus.tlb_op = 4'b0100;
        bus.entry_hi_W = 32'h00C0_0003; bus.entry_lo0_W = 32'h0000_5003;
        bus.entry_lo1_W = 32'h0000_5003; bus.index_W = 32'd5;
        tick;
        bus.op_valid = 1'b0; bus.tlb_op = 4'h0;
        resetn = 1'b0;
        tick;
        chk("abort_done0", {31'h0, bus.op_done}, 32'h0);
        resetn = 1'b1;
        tick;
        chk("abort_done1", {30'h0, bus.op_ready, bus.op_done}, 32'h2);
        chk("abort_idx_rst", bus.index_out, 32'h0);
        translate(32'h00C0_0000, 1'b0, 8'd3);
        chk_tr("abort_miss", 32'h0, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
